timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped countdown timer on the CPU data bus, directly downstream of the pipeline's M stage. It decodes `m_data_addr`/`m_data_byteen`/`m_data_wdata` and returns read data combinationally on `m_data_rdata` within the same M-stage cycle. Its interrupt output drives one bit of the CPU's `HWInt[5:0]`. It holds three word registers, CTRL, PRESET and COUNT, and a four-state counting FSM with one-shot and auto-reload modes.

## Interface
- `BASE`, default 32'h0000_7F00: word-aligned base address; block occupies BASE..BASE+0xF.
- `clk`  in  1  system clock, shared with CPU.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  32  byte address from CPU `m_data_addr`.
- `byteen`  in  4  byte write enables from CPU `m_data_byteen`; nonzero means write (already 0 when CPU takes an exception).
- `wdata`  in  32  write data from CPU `m_data_wdata`.
- `rdata`  out  32  read data, combinational; to CPU `m_data_rdata` mux.
- `irq`  out  1  interrupt request, to one `HWInt` bit.

## Operation
- Decode: `hit = (addr[31:4] == BASE[31:4])`. Offset `addr[3:2]`: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `rdata` when `hit`: CTRL is zero-extended from 4 bits, PRESET and COUNT are returned as full words, offset 3 returns 0. When not `hit`, `rdata` = 0.
- Write condition: `hit & (byteen != 0)`. Each byte lane i is updated only where `byteen[i]`.
  - CTRL keeps bits [3:0] only; upper bits are discarded.
  - COUNT and offset 3 are read-only; writes to them are ignored.
- CTRL fields:
  - [0] EN: count enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10/11 behave as 00.
  - [3] IM: interrupt mask, 1 = allow.
- Internal flag `pend`. `irq = CTRL[3] & pend`.
- A write to CTRL or PRESET clears `pend` on the same edge.
- FSM states, evaluated each edge after any bus write:
  - IDLE: if EN go to LOAD, otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT-1.
    - Else COUNT <= 0, `pend` <= 1, go to INT.
  - INT:
    - MODE 00: EN <= 0 and go to IDLE; `pend` is held.
    - MODE 01: `pend` <= 0 and go to IDLE; EN stays 1, so the timer reloads.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the INT-state EN clear: the bus-written value wins.
  - A bus write to PRESET during CNT does not affect COUNT until the next LOAD.
- Reset: CTRL = 0, PRESET = 0, COUNT = 0, `pend` = 0, state IDLE. Hence `irq` = 0 and `rdata` = 0 for non-hit addresses. Reset overrides any same-cycle write. Reset in any state returns to IDLE on that edge.

## Timing
- Register writes take effect at the edge that ends the M-stage cycle. Reads have zero latency and reflect the pre-edge state.
- Edge numbering: PRESET = N ≥ 2 is already loaded, and EN is written at edge 0.
  - Edge 1: LOAD.
  - Edge 2: COUNT = N.
  - Edge k, for 2 ≤ k ≤ N+1: COUNT = N+2−k.
  - Edge N+2: COUNT = 0, state INT, `pend` = 1.
- PRESET = 0 or 1: `pend` rises at edge 3.
- Auto-reload: `pend` is high for exactly one cycle; the period between `pend` rises is N+3 cycles.
- One-shot: `pend` stays high until a CTRL or PRESET write. EN reads 0 after edge N+3.
- Clearing EN during CNT: the FSM is in IDLE after the next edge and COUNT is frozen at its last value.

## Test plan
- **Reset:** hold reset 2 cycles. Required: read CTRL/PRESET/COUNT = 0, `irq` = 0. Read of address BASE+0x20 returns 0.
- **One-shot:**
  - Stimulus: write PRESET = 5, then CTRL = 0x9 at edge 0.
  - Required: COUNT reads 5,4,3,2,1 after edges 2..6; `irq` = 1 after edge 7; CTRL reads 0x8 after edge 8; `irq` stays 1.
  - Then write CTRL = 0: `irq` = 0 on the next cycle.
- **Auto-reload:**
  - Stimulus: PRESET = 3, CTRL = 0xB.
  - Required: `irq` pulses one cycle at edges 5, 11 and 17 (period 6).
  - Then with CTRL = 0x3 (IM = 0): `pend` still toggles but `irq` = 0.
- **Byte lanes:**
  - Stimulus: write PRESET with byteen = 4'b0010 and wdata = 0xAABBCCDD over PRESET = 0x11223344.
  - Required: PRESET reads 0x1122CC44.
  - Write to COUNT: value unchanged.
- **Pause/edge cases:**
  - Stimulus: clear EN mid-count at COUNT = 7. Required: COUNT holds 7 and state goes IDLE. Re-set EN: COUNT reloads from PRESET.
  - Stimulus: PRESET = 0. Required: `irq` at edge 3.
- **Reset mid-count and write/FSM collision:**
  - Stimulus: assert reset while in CNT. Required: all registers 0 on the next edge.
  - Stimulus: write CTRL = 0x1 in the INT cycle of one-shot mode. Required: EN remains 1 and the timer restarts.

Source files
------------

// File: rtl/timer_counter_if.sv
`timescale 1ns/1ps
// CPU data-bus view of the countdown timer: M-stage address/byte-enable/write
// data towards the timer, combinational read data and interrupt back.
interface timer_counter_if;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (output addr, output byteen, output wdata, input rdata, input irq);
   modport slave  (input addr, input byteen, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
`timescale 1ns/1ps
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// counting FSM with one-shot and auto-reload modes, and a masked interrupt.
// Bus writes are applied after the FSM update so that a CPU write always wins
// over the FSM's own update of the same register on the same edge.
module timer_counter #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic            clk,
   input  logic            reset,
   timer_counter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;

   state_t      state_q;
   logic [3:0]  ctrl_q;
   logic [31:0] preset_q;
   logic [31:0] count_q;
   logic        pend_q;

   logic [3:0]  ctrl_d;
   logic [31:0] preset_d;
   logic        hit;
   logic        wr_en;
   logic        wr_ctrl;
   logic        wr_preset;
   logic [1:0]  offset;

   assign hit       = (bus.addr[31:4] == BASE[31:4]);
   assign offset    = bus.addr[3:2];
   assign wr_en     = hit && (bus.byteen != 4'b0000);
   assign wr_ctrl   = wr_en && (offset == OFF_CTRL);
   assign wr_preset = wr_en && (offset == OFF_PRESET);

   // CTRL only keeps its low nibble, which lives entirely in byte lane 0
   assign ctrl_d = bus.byteen[0] ? bus.wdata[3:0] : ctrl_q;

   // PRESET merge: each lane is replaced only where its byte enable is set
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_preset_lane
         assign preset_d[gi*8 +: 8] = bus.byteen[gi] ? bus.wdata[gi*8 +: 8]
                                                     : preset_q[gi*8 +: 8];
      end
   endgenerate

   // Zero-latency read mux reflecting the pre-edge register state
   always_comb begin
      bus.rdata = 32'd0;
      if (hit) begin
         case (offset)
            OFF_CTRL:   bus.rdata = {28'd0, ctrl_q};
            OFF_PRESET: bus.rdata = preset_q;
            OFF_COUNT:  bus.rdata = count_q;
            default:    bus.rdata = 32'd0;
         endcase
      end
   end

   assign bus.irq = ctrl_q[3] & pend_q;

   // Counting FSM followed by bus writes; the later assignments take priority
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= 4'd0;
         preset_q <= 32'd0;
         count_q  <= 32'd0;
         pend_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ctrl_q[0]) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               count_q <= preset_q;
               state_q <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_q[0]) begin
                  state_q <= ST_IDLE;
               end else if (count_q > 32'd1) begin
                  count_q <= count_q - 32'd1;
               end else begin
                  count_q <= 32'd0;
                  pend_q  <= 1'b1;
                  state_q <= ST_INT;
               end
            end
            ST_INT: begin
               // Only MODE 01 reloads; 00, 10 and 11 all behave as one-shot
               if (ctrl_q[2:1] == 2'b01) pend_q    <= 1'b0;
               else                      ctrl_q[0] <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase

         if (wr_ctrl) begin
            ctrl_q <= ctrl_d;
            pend_q <= 1'b0;
         end
         if (wr_preset) begin
            preset_q <= preset_d;
            pend_q   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer_counter.sv
`timescale 1ns/1ps
// Directed bench for timer_counter: expected values are queued when a
// transaction is issued and compared when the DUT output is sampled.
module tb_timer_counter;

   localparam logic [31:0] BASE   = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_PRE  = BASE + 32'h4;
   localparam logic [31:0] A_CNT  = BASE + 32'h8;
   localparam logic [31:0] A_RSV  = BASE + 32'hC;
   localparam logic [31:0] A_MISS = BASE + 32'h20;

   logic clk;
   logic reset;

   timer_counter_if bus ();

   timer_counter #(.BASE(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int checks_cnt = 0;
   int errors_cnt = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Pop the oldest expectation and compare it with the sampled DUT value
   task automatic sb_compare(input logic [31:0] got);
      sb_entry_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, got, e.exp);
      end
   endtask

   // Advance one edge; inputs change 1ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.addr   = a;
      bus.byteen = be;
      bus.wdata  = d;
      $display("t=%0t WR addr=0x%08h be=%b data=0x%08h", $time, a, be, d);
      cyc();
      bus.byteen = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      bus.addr   = a;
      bus.byteen = 4'b0000;
      sb_q.push_back('{tag, exp});
      #1;
      $display("t=%0t RD %s addr=0x%08h data=0x%08h", $time, tag, a, bus.rdata);
      sb_compare(bus.rdata);
   endtask

   task automatic irq_is(input logic exp, input string tag);
      sb_q.push_back('{tag, {31'd0, exp}});
      #1;
      $display("t=%0t IRQ %s irq=%b", $time, tag, bus.irq);
      sb_compare({31'd0, bus.irq});
   endtask

   task automatic stop_timer();
      wr(A_CTRL, 4'hF, 32'h0);
      repeat (3) cyc();
   endtask

   initial begin
      bus.addr   = 32'd0;
      bus.byteen = 4'b0000;
      bus.wdata  = 32'd0;
      reset      = 1'b1;
      #1;
      repeat (2) cyc();
      reset = 1'b0;

      // Reset state
      rd(A_CTRL, 32'd0, "rst_ctrl");
      rd(A_PRE,  32'd0, "rst_preset");
      rd(A_CNT,  32'd0, "rst_count");
      rd(A_MISS, 32'd0, "rst_miss");
      irq_is(1'b0, "rst_irq");

      // One-shot, N = 5: EN written at edge 0
      wr(A_PRE, 4'hF, 32'd5);
      wr(A_CTRL, 4'hF, 32'h9);
      cyc();                                         // edge 1: LOAD
      for (int i = 0; i < 5; i++) begin
         cyc();                                      // edges 2..6
         rd(A_CNT, 32'(5 - i), $sformatf("os_count_e%0d", i + 2));
         irq_is(1'b0, $sformatf("os_irq_low_e%0d", i + 2));
      end
      cyc();                                         // edge 7
      irq_is(1'b1, "os_irq_e7");
      rd(A_CNT, 32'd0, "os_count_e7");
      cyc();                                         // edge 8: EN auto-cleared
      rd(A_CTRL, 32'h8, "os_ctrl_e8");
      irq_is(1'b1, "os_irq_e8");
      cyc();
      irq_is(1'b1, "os_irq_held");
      wr(A_CTRL, 4'hF, 32'h0);
      irq_is(1'b0, "os_irq_cleared");

      // Byte lanes, read-only locations, CTRL width
      wr(A_PRE, 4'hF, 32'h1122_3344);
      wr(A_PRE, 4'b0010, 32'hAABB_CCDD);
      rd(A_PRE, 32'h1122_CC44, "bl_preset");
      rd(A_MISS, 32'd0, "bl_miss");
      wr(A_CNT, 4'hF, 32'hFFFF_FFFF);
      rd(A_CNT, 32'd0, "bl_count_ro");
      wr(A_RSV, 4'hF, 32'hFFFF_FFFF);
      rd(A_RSV, 32'd0, "bl_rsv");
      wr(A_CTRL, 4'hF, 32'h0000_00F0);
      rd(A_CTRL, 32'd0, "bl_ctrl_upper");

      // Auto-reload, N = 3: pulses at edges 5, 11, 17
      wr(A_PRE, 4'hF, 32'd3);
      wr(A_CTRL, 4'hF, 32'hB);
      for (int e = 1; e <= 18; e++) begin
         cyc();
         irq_is((e == 5) || (e == 11) || (e == 17), $sformatf("ar_irq_e%0d", e));
      end
      wr(A_CTRL, 4'hF, 32'h3);                       // IM = 0
      for (int e = 1; e <= 14; e++) begin
         cyc();
         irq_is(1'b0, $sformatf("ar_masked_e%0d", e));
      end
      stop_timer();

      // Pause at COUNT = 7 with N = 10, then resume with reload
      wr(A_PRE, 4'hF, 32'd10);
      wr(A_CTRL, 4'hF, 32'h1);                       // edge 0
      repeat (4) cyc();                              // edges 1..4
      rd(A_CNT, 32'd8, "pz_count_e4");
      wr(A_CTRL, 4'hF, 32'h0);                       // edge 5: COUNT -> 7
      rd(A_CNT, 32'd7, "pz_count_e5");
      repeat (4) cyc();
      rd(A_CNT, 32'd7, "pz_count_held");
      wr(A_CTRL, 4'hF, 32'h1);                       // re-enable, edge 0
      cyc();                                         // edge 1: LOAD
      rd(A_CNT, 32'd7, "pz_count_load");
      cyc();                                         // edge 2: reload
      rd(A_CNT, 32'd10, "pz_count_reload");
      cyc();
      rd(A_CNT, 32'd9, "pz_count_dec");
      stop_timer();

      // PRESET = 0: pend rises at edge 3
      wr(A_PRE, 4'hF, 32'd0);
      wr(A_CTRL, 4'hF, 32'h9);
      cyc();
      irq_is(1'b0, "p0_irq_e1");
      cyc();
      irq_is(1'b0, "p0_irq_e2");
      cyc();
      irq_is(1'b1, "p0_irq_e3");
      cyc();
      rd(A_CTRL, 32'h8, "p0_ctrl_e4");

      // CTRL write during the INT cycle of one-shot keeps EN and restarts
      wr(A_PRE, 4'hF, 32'd2);
      irq_is(1'b0, "col_preset_clr");
      wr(A_CTRL, 4'hF, 32'h9);                       // edge 0
      repeat (4) cyc();                              // edge 4: INT
      irq_is(1'b1, "col_irq_e4");
      wr(A_CTRL, 4'hF, 32'h1);                       // edge 5, collides with EN clear
      rd(A_CTRL, 32'h1, "col_ctrl_e5");
      irq_is(1'b0, "col_irq_e5");
      cyc();                                         // edge 6: LOAD
      rd(A_CNT, 32'd0, "col_count_e6");
      cyc();                                         // edge 7: reload
      rd(A_CNT, 32'd2, "col_count_e7");
      stop_timer();

      // Reset while counting, together with a PRESET write
      wr(A_PRE, 4'hF, 32'h100);
      wr(A_CTRL, 4'hF, 32'h9);
      repeat (5) cyc();
      rd(A_CNT, 32'hFD, "mr_count_pre");
      reset      = 1'b1;
      bus.addr   = A_PRE;
      bus.byteen = 4'hF;
      bus.wdata  = 32'h1234_5678;
      cyc();
      reset      = 1'b0;
      bus.byteen = 4'b0000;
      rd(A_CTRL, 32'd0, "mr_ctrl");
      rd(A_PRE,  32'd0, "mr_preset");
      rd(A_CNT,  32'd0, "mr_count");
      irq_is(1'b0, "mr_irq");
      repeat (3) cyc();
      rd(A_CNT, 32'd0, "mr_count_idle");

      if (sb_q.size() != 0) check_val("sb_leftover", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
